// File: rtl/app_dma_copy_engine_if.sv
// MPF-side read/write request and response channels of the DMA copy engine.
// The master modport is the engine side; the slave modport is the memory side.
interface app_dma_copy_engine_if #(
    parameter int unsigned CL_ADDR_W  = 42,
    parameter int unsigned LINE_CNT_W = 16,
    parameter int unsigned DATA_W     = 512
);
    logic                  rd_req_valid;
    logic [CL_ADDR_W-1:0]  rd_req_addr;
    logic [LINE_CNT_W-1:0] rd_req_tag;
    logic                  rd_almfull;
    logic                  rd_rsp_valid;
    logic [LINE_CNT_W-1:0] rd_rsp_tag;
    logic [DATA_W-1:0]     rd_rsp_data;
    logic                  wr_req_valid;
    logic [CL_ADDR_W-1:0]  wr_req_addr;
    logic [DATA_W-1:0]     wr_req_data;
    logic                  wr_almfull;
    logic                  wr_rsp_valid;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_tag,
        input  rd_almfull, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        output wr_req_valid, wr_req_addr, wr_req_data,
        input  wr_almfull, wr_rsp_valid
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_tag,
        output rd_almfull, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        input  wr_req_valid, wr_req_addr, wr_req_data,
        output wr_almfull, wr_rsp_valid
    );
endinterface

// File: rtl/app_dma_copy_engine.sv
// Multi-line DMA engine: copies NUM_LINES cache lines src->dst, or fills dst with a
// replicated 64-bit pattern; keeps several reads in flight and accepts out-of-order returns.
module app_dma_copy_engine #(
    parameter int unsigned CL_ADDR_W       = 42,
    parameter int unsigned LINE_CNT_W      = 16,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned DATA_W          = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [CL_ADDR_W+5:0]  src_byte_addr,
    input  logic [CL_ADDR_W+5:0]  dst_byte_addr,
    input  logic [LINE_CNT_W-1:0] num_lines,
    input  logic [63:0]           fill_pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  err_start_busy,
    output logic [LINE_CNT_W-1:0] lines_written,
    app_dma_copy_engine_if.master mem
);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [LINE_CNT_W-1:0] tag;
        logic [DATA_W-1:0]     data;
    } rsp_entry_t;

    state_t                state_q, state_d;
    logic                  mode_q;
    logic [CL_ADDR_W-1:0]  src_line_q, dst_line_q;
    logic [LINE_CNT_W-1:0] num_q;
    logic [63:0]           pat_q;
    logic                  zero_pend_q;
    logic [LINE_CNT_W-1:0] rd_issue_idx, wr_issue_idx;
    logic [CNT_W-1:0]      inflight, fifo_count;
    logic [PTR_W-1:0]      fifo_wr_ptr, fifo_rd_ptr;
    rsp_entry_t            fifo_mem [MAX_OUTSTANDING];
    rsp_entry_t            fifo_head_c;
    logic [OCC_W-1:0]      occupancy_c;
    logic                  credit_ok_c;
    logic                  job_start_c, do_rd_c, do_wr_c, finish_c;
    logic                  fifo_push_c, fifo_pop_c;
    logic                  unused_addr_bits_c;

    assign unused_addr_bits_c = ^{src_byte_addr[5:0], dst_byte_addr[5:0]};
    assign occupancy_c = OCC_W'(inflight) + OCC_W'(fifo_count);
    assign credit_ok_c = occupancy_c < OCC_W'(MAX_OUTSTANDING);
    assign fifo_head_c = fifo_mem[fifo_rd_ptr];
    // Responses are only meaningful for an active copy job.
    assign fifo_push_c = mem.rd_rsp_valid && (state_q != IDLE) && !mode_q;
    assign fifo_pop_c  = do_wr_c && !mode_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_start_c && (num_lines != '0)) state_d = RUN;
            RUN:     if (do_wr_c && (wr_issue_idx == num_q - LINE_CNT_W'(1))) state_d = DRAIN;
            DRAIN:   if (finish_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-cycle control strobes
    always_comb begin
        job_start_c = 1'b0;
        do_rd_c     = 1'b0;
        do_wr_c     = 1'b0;
        finish_c    = 1'b0;
        case (state_q)
            IDLE: begin
                job_start_c = start && !busy;
                finish_c    = zero_pend_q;
            end
            RUN: begin
                do_rd_c = !mode_q && (rd_issue_idx < num_q) && !mem.rd_almfull && credit_ok_c;
                do_wr_c = !mem.wr_almfull &&
                          (mode_q ? (wr_issue_idx < num_q) : (fifo_count != '0));
            end
            DRAIN:   finish_c = (lines_written == num_q);
            default: ;
        endcase
    end

    // Job registers, counters and registered request outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q           <= 1'b0;
            src_line_q       <= '0;
            dst_line_q       <= '0;
            num_q            <= '0;
            pat_q            <= '0;
            zero_pend_q      <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_start_busy   <= 1'b0;
            lines_written    <= '0;
            rd_issue_idx     <= '0;
            wr_issue_idx     <= '0;
            inflight         <= '0;
            fifo_count       <= '0;
            fifo_wr_ptr      <= '0;
            fifo_rd_ptr      <= '0;
            mem.rd_req_valid <= 1'b0;
            mem.rd_req_addr  <= '0;
            mem.rd_req_tag   <= '0;
            mem.wr_req_valid <= 1'b0;
            mem.wr_req_addr  <= '0;
            mem.wr_req_data  <= '0;
        end else begin
            mem.rd_req_valid <= do_rd_c;
            mem.wr_req_valid <= do_wr_c;

            if (job_start_c) begin
                mode_q         <= mode;
                src_line_q     <= src_byte_addr[CL_ADDR_W+5:6];
                dst_line_q     <= dst_byte_addr[CL_ADDR_W+5:6];
                num_q          <= num_lines;
                pat_q          <= fill_pattern;
                zero_pend_q    <= (num_lines == '0);
                busy           <= 1'b1;
                done           <= 1'b0;
                err_start_busy <= 1'b0;
                lines_written  <= '0;
                rd_issue_idx   <= '0;
                wr_issue_idx   <= '0;
            end else if (mem.wr_rsp_valid && busy) begin
                lines_written <= lines_written + LINE_CNT_W'(1);
            end

            if (start && busy) err_start_busy <= 1'b1;

            if (finish_c) begin
                done        <= 1'b1;
                busy        <= 1'b0;
                zero_pend_q <= 1'b0;
            end

            if (do_rd_c) begin
                mem.rd_req_addr <= src_line_q + CL_ADDR_W'(rd_issue_idx);
                mem.rd_req_tag  <= rd_issue_idx;
                rd_issue_idx    <= rd_issue_idx + LINE_CNT_W'(1);
            end

            // Copy writes are addressed by the returned tag, not issue order.
            if (do_wr_c) begin
                wr_issue_idx <= wr_issue_idx + LINE_CNT_W'(1);
                if (mode_q) begin
                    mem.wr_req_addr <= dst_line_q + CL_ADDR_W'(wr_issue_idx);
                    mem.wr_req_data <= DATA_W'({8{pat_q}});
                end else begin
                    mem.wr_req_addr <= dst_line_q + CL_ADDR_W'(fifo_head_c.tag);
                    mem.wr_req_data <= fifo_head_c.data;
                end
            end

            inflight    <= inflight + CNT_W'(do_rd_c) - CNT_W'(fifo_push_c);
            fifo_count  <= fifo_count + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
            if (fifo_push_c) fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            if (fifo_pop_c)  fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
        end
    end

    // Response buffer storage
    always_ff @(posedge clk) begin
        if (fifo_push_c) fifo_mem[fifo_wr_ptr] <= {mem.rd_rsp_tag, mem.rd_rsp_data};
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push_c && !fifo_pop_c && (fifo_count == CNT_W'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_app_dma_copy_engine.sv
// Directed bench for app_dma_copy_engine: memory responder model, write scoreboard,
// and one task per scenario.
module tb_app_dma_copy_engine;
    localparam int unsigned CL_ADDR_W  = 42;
    localparam int unsigned LINE_CNT_W = 16;
    localparam int unsigned MAX_OUT    = 16;
    localparam int unsigned DATA_W     = 512;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic                  mode = 1'b0;
    logic [CL_ADDR_W+5:0]  src_byte_addr = '0;
    logic [CL_ADDR_W+5:0]  dst_byte_addr = '0;
    logic [LINE_CNT_W-1:0] num_lines = '0;
    logic [63:0]           fill_pattern = '0;
    logic                  busy, done, err_start_busy;
    logic [LINE_CNT_W-1:0] lines_written;

    app_dma_copy_engine_if #(.CL_ADDR_W(CL_ADDR_W), .LINE_CNT_W(LINE_CNT_W), .DATA_W(DATA_W)) mem_if ();

    app_dma_copy_engine #(
        .CL_ADDR_W(CL_ADDR_W), .LINE_CNT_W(LINE_CNT_W),
        .MAX_OUTSTANDING(MAX_OUT), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_byte_addr(src_byte_addr), .dst_byte_addr(dst_byte_addr),
        .num_lines(num_lines), .fill_pattern(fill_pattern),
        .busy(busy), .done(done), .err_start_busy(err_start_busy),
        .lines_written(lines_written), .mem(mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LINE_CNT_W-1:0] tag;
        logic [CL_ADDR_W-1:0]  addr;
        int                    due;
    } rd_item_t;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0;
    int rd_count, wr_count, wr_err, rd_addr_err, stall_viol, rsp_sent, max_out, first_rd_cyc;
    logic [CL_ADDR_W-1:0] first_rd_addr, first_wr_addr;
    logic [CL_ADDR_W-1:0] exp_src, exp_dst;
    int                   exp_n;
    bit                   exp_fill;
    logic [63:0]          exp_pat;
    bit                   seen [64];
    int                   rsp_lat = 5;
    bit                   rev_mode = 1'b0;
    int                   rev_n = 0;
    bit                   releasing = 1'b0;
    rd_item_t             rd_q [$];
    int                   ack_q [$];

    function automatic logic [DATA_W-1:0] line_data(input logic [CL_ADDR_W-1:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'hC0DE_0000;
        return {8{w, ~w}};
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input logic [CL_ADDR_W-1:0] idx);
        if (exp_fill) return {8{exp_pat}};
        return line_data(exp_src + idx);
    endfunction

    // Monitor / scoreboard: samples registered outputs just after each rising edge
    initial begin
        forever begin
            logic [CL_ADDR_W-1:0] idx;
            @(posedge clk);
            #1;
            cyc++;
            if (reset_n) begin
                if (mem_if.rd_req_valid) begin
                    if (rd_count == 0) begin
                        first_rd_cyc  = cyc;
                        first_rd_addr = mem_if.rd_req_addr;
                    end
                    rd_count++;
                    if (mem_if.rd_req_addr !== exp_src + CL_ADDR_W'(mem_if.rd_req_tag)) rd_addr_err++;
                    rd_q.push_back('{mem_if.rd_req_tag, mem_if.rd_req_addr, cyc + rsp_lat});
                    if (rd_count - rsp_sent > max_out) max_out = rd_count - rsp_sent;
                end
                if (mem_if.wr_req_valid) begin
                    if (wr_count == 0) first_wr_addr = mem_if.wr_req_addr;
                    wr_count++;
                    if (mem_if.wr_almfull) stall_viol++;
                    idx = mem_if.wr_req_addr - exp_dst;
                    if (idx >= CL_ADDR_W'(exp_n) || seen[idx[5:0]] || mem_if.wr_req_data !== exp_data(idx))
                        wr_err++;
                    else
                        seen[idx[5:0]] = 1'b1;
                    ack_q.push_back(cyc + 3);
                end
            end
        end
    end

    // Memory responder: drives read responses and write acks on the falling edge
    initial begin
        mem_if.rd_almfull   = 1'b0;
        mem_if.wr_almfull   = 1'b0;
        mem_if.rd_rsp_valid = 1'b0;
        mem_if.rd_rsp_tag   = '0;
        mem_if.rd_rsp_data  = '0;
        mem_if.wr_rsp_valid = 1'b0;
        forever begin
            rd_item_t it;
            bit       send;
            @(negedge clk);
            mem_if.rd_rsp_valid = 1'b0;
            mem_if.wr_rsp_valid = 1'b0;
            send = 1'b0;
            if (!reset_n) begin
                rd_q.delete();
                ack_q.delete();
                releasing = 1'b0;
            end else begin
                if (rev_mode) begin
                    if (rev_n > 0 && rd_q.size() == rev_n) releasing = 1'b1;
                    if (releasing && rd_q.size() > 0) begin
                        it = rd_q.pop_back();
                        send = 1'b1;
                    end
                    if (rd_q.size() == 0) releasing = 1'b0;
                end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                    it = rd_q.pop_front();
                    send = 1'b1;
                end
                if (send) begin
                    mem_if.rd_rsp_valid = 1'b1;
                    mem_if.rd_rsp_tag   = it.tag;
                    mem_if.rd_rsp_data  = line_data(it.addr);
                    rsp_sent++;
                end
                if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
                    void'(ack_q.pop_front());
                    mem_if.wr_rsp_valid = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input bit m, input logic [CL_ADDR_W+5:0] s, input logic [CL_ADDR_W+5:0] d,
                               input int n, input logic [63:0] p);
        exp_src = s[CL_ADDR_W+5:6];
        exp_dst = d[CL_ADDR_W+5:6];
        exp_n = n; exp_fill = m; exp_pat = p;
        rd_count = 0; wr_count = 0; wr_err = 0; rd_addr_err = 0;
        stall_viol = 0; rsp_sent = 0; max_out = 0; first_rd_cyc = -1;
        foreach (seen[i]) seen[i] = 1'b0;
        @(negedge clk);
        mode = m; src_byte_addr = s; dst_byte_addr = d;
        num_lines = LINE_CNT_W'(n); fill_pattern = p;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err_start_busy, mem_if.rd_req_valid, mem_if.wr_req_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, done, err_start_busy, mem_if.rd_req_valid, mem_if.wr_req_valid});
        end
        checks++;
        if (lines_written !== '0) begin
            failures++; $display("FAIL reset_lines_written: got %0d expected 0", lines_written);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_copy_in_order();
        bit ok;
        rsp_lat = 5; rev_mode = 1'b0;
        pulse_start(1'b0, 48'h1000, 48'h8000, 4, 64'h0);
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL copy4_done: got 0 expected 1"); end
        checks++; if (first_rd_cyc !== start_cyc + 2) begin
            failures++; $display("FAIL copy4_latency: got %0d expected %0d", first_rd_cyc - start_cyc, 2); end
        checks++; if (first_rd_addr !== 42'h40) begin
            failures++; $display("FAIL copy4_first_rd_addr: got %0h expected 40", first_rd_addr); end
        checks++; if (first_wr_addr !== 42'h200) begin
            failures++; $display("FAIL copy4_first_wr_addr: got %0h expected 200", first_wr_addr); end
        checks++; if (rd_count !== 4 || rd_addr_err !== 0) begin
            failures++; $display("FAIL copy4_reads: got %0d (addr errs %0d) expected 4 (0)", rd_count, rd_addr_err); end
        checks++; if (wr_count !== 4 || wr_err !== 0) begin
            failures++; $display("FAIL copy4_writes: got %0d (errs %0d) expected 4 (0)", wr_count, wr_err); end
        checks++; if (lines_written !== 16'd4 || busy !== 1'b0) begin
            failures++; $display("FAIL copy4_status: got lw=%0d busy=%b expected lw=4 busy=0", lines_written, busy); end
    endtask

    task automatic test_credit_limit();
        bit ok;
        rsp_lat = 50; rev_mode = 1'b0;
        pulse_start(1'b0, 48'h10000, 48'h40000, 32, 64'h0);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL credit_done: got 0 expected 1"); end
        checks++; if (max_out !== 16) begin
            failures++; $display("FAIL credit_max_outstanding: got %0d expected 16", max_out); end
        checks++; if (wr_count !== 32 || wr_err !== 0 || rd_addr_err !== 0) begin
            failures++; $display("FAIL credit_writes: got %0d (errs %0d/%0d) expected 32 (0/0)",
                                 wr_count, wr_err, rd_addr_err); end
        checks++; if (lines_written !== 16'd32) begin
            failures++; $display("FAIL credit_lines_written: got %0d expected 32", lines_written); end
        rsp_lat = 5;
    endtask

    task automatic test_out_of_order();
        bit ok;
        rev_mode = 1'b1; rev_n = 8;
        pulse_start(1'b0, 48'h1000, 48'h8000, 8, 64'h0);
        wait_done(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ooo_done: got 0 expected 1"); end
        checks++; if (first_wr_addr !== 42'h207) begin
            failures++; $display("FAIL ooo_first_wr_addr: got %0h expected 207", first_wr_addr); end
        checks++; if (wr_count !== 8 || wr_err !== 0 || rd_count !== 8) begin
            failures++; $display("FAIL ooo_writes: got wr=%0d errs=%0d rd=%0d expected 8/0/8",
                                 wr_count, wr_err, rd_count); end
        rev_mode = 1'b0; rev_n = 0;
    endtask

    task automatic test_fill_stall();
        bit ok;
        @(negedge clk);
        mem_if.wr_almfull = 1'b1;
        // Destination at the top of the line space: the three writes wrap to lines 0 and 1.
        pulse_start(1'b1, 48'hFFFF_FFFF_FFC0, 48'hFFFF_FFFF_FFC0, 3, 64'hDEADBEEF_CAFEF00D);
        repeat (9) @(negedge clk);
        checks++; if (wr_count !== 0) begin
            failures++; $display("FAIL fill_stall_writes: got %0d expected 0", wr_count); end
        mem_if.wr_almfull = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fill_done: got 0 expected 1"); end
        checks++; if (wr_count !== 3 || wr_err !== 0) begin
            failures++; $display("FAIL fill_writes: got %0d (errs %0d) expected 3 (0)", wr_count, wr_err); end
        checks++; if (rd_count !== 0 || stall_viol !== 0) begin
            failures++; $display("FAIL fill_no_reads: got rd=%0d stall_viol=%0d expected 0/0", rd_count, stall_viol); end
        checks++; if (lines_written !== 16'd3) begin
            failures++; $display("FAIL fill_lines_written: got %0d expected 3", lines_written); end
    endtask

    task automatic test_zero_lines();
        pulse_start(1'b0, 48'h1000, 48'h8000, 0, 64'h0);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL zero_first_cycle: got busy=%b done=%b expected 1/0", busy, done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL zero_done: got busy=%b done=%b expected 0/1", busy, done); end
        repeat (5) @(negedge clk);
        checks++; if (rd_count !== 0 || wr_count !== 0) begin
            failures++; $display("FAIL zero_no_requests: got rd=%0d wr=%0d expected 0/0", rd_count, wr_count); end
    endtask

    task automatic test_start_busy();
        bit ok;
        rsp_lat = 3;
        pulse_start(1'b0, 48'h2000, 48'h20000, 16, 64'h0);
        repeat (4) @(negedge clk);
        mode = 1'b1; num_lines = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (err_start_busy !== 1'b1) begin
            failures++; $display("FAIL busy_err_flag: got %b expected 1", err_start_busy); end
        wait_done(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL busy_done: got 0 expected 1"); end
        checks++; if (wr_count !== 16 || wr_err !== 0 || rd_count !== 16) begin
            failures++; $display("FAIL busy_job_intact: got wr=%0d errs=%0d rd=%0d expected 16/0/16",
                                 wr_count, wr_err, rd_count); end
        checks++; if (lines_written !== 16'd16 || err_start_busy !== 1'b1) begin
            failures++; $display("FAIL busy_status: got lw=%0d err=%b expected 16/1", lines_written, err_start_busy); end
        rsp_lat = 5;
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int n;
        rsp_lat = 5;
        pulse_start(1'b0, 48'h1000, 48'h8000, 20, 64'h0);
        n = 0;
        while (wr_count < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++; if (wr_count < 5) begin
            failures++; $display("FAIL midreset_reach5: got %0d expected 5", wr_count); end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, done, mem_if.rd_req_valid, mem_if.wr_req_valid} !== 4'b0 || lines_written !== '0) begin
            failures++; $display("FAIL midreset_outputs: got %b lw=%0d expected 0000 lw=0",
                                 {busy, done, mem_if.rd_req_valid, mem_if.wr_req_valid}, lines_written); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(1'b0, 48'h3000, 48'h9000, 2, 64'h0);
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL postreset_done: got 0 expected 1"); end
        checks++; if (wr_count !== 2 || wr_err !== 0 || lines_written !== 16'd2) begin
            failures++; $display("FAIL postreset_job: got wr=%0d errs=%0d lw=%0d expected 2/0/2",
                                 wr_count, wr_err, lines_written); end
    endtask

    initial begin
        test_reset();
        test_copy_in_order();
        test_credit_limit();
        test_out_of_order();
        test_fill_stall();
        test_zero_lines();
        test_start_busy();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
